// File: rtl/mux_21.sv
// Registered 2:1 valid-qualified selector with drop flag and stall.
// Optional even parity on the output when MUX21_PARITY_EN is defined.
module mux_21 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             sel,
  input  logic [WIDTH-1:0] in_a,
  input  logic             in_a_valid,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_b_valid,
  input  logic             hold,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic             out_src,
`ifdef MUX21_PARITY_EN
  output logic             out_drop,
  output logic             out_parity
`else
  output logic             out_drop
`endif
);

  logic             sv;
  logic             uv;
  logic [WIDTH-1:0] sel_data;

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             src_q, src_d;
  logic             drop_q, drop_d;

  assign sv       = sel ? in_b_valid : in_a_valid;
  assign uv       = sel ? in_a_valid : in_b_valid;
  assign sel_data = sel ? in_b : in_a;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    src_d   = src_q;
    drop_d  = drop_q;
    if (!hold) begin
      valid_d = sv;
      drop_d  = uv;
      // Last captured data stays visible while qualified low.
      if (sv) begin
        data_d = sel_data;
        src_d  = sel;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      src_q   <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      src_q   <= src_d;
      drop_q  <= drop_d;
    end
  end

  assign out       = data_q;
  assign out_valid = valid_q;
  assign out_src   = src_q;
  assign out_drop  = drop_q;

`ifdef MUX21_PARITY_EN
  logic par_q, par_d;

  assign par_d = (!hold && sv) ? ^sel_data : par_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      par_q <= 1'b0;
    end else begin
      par_q <= par_d;
    end
  end

  assign out_parity = par_q;
`endif

endmodule

// File: tb/tb_mux_21.sv
// Bench for mux_21: directed vectors feed a scoreboard queue;
// a monitor compares one registered output per clock.
module tb_mux_21;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       sel = 1'b0;
  logic [7:0] in_a = '0;
  logic       in_a_valid = 1'b0;
  logic [7:0] in_b = '0;
  logic       in_b_valid = 1'b0;
  logic       hold = 1'b0;
  logic [7:0] out;
  logic       out_valid;
  logic       out_src;
  logic       out_drop;
  logic       out_parity;

  mux_21 #(.WIDTH(8)) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .sel        (sel),
    .in_a       (in_a),
    .in_a_valid (in_a_valid),
    .in_b       (in_b),
    .in_b_valid (in_b_valid),
    .hold       (hold),
    .out        (out),
    .out_valid  (out_valid),
    .out_src    (out_src),
`ifdef MUX21_PARITY_EN
    .out_drop   (out_drop),
    .out_parity (out_parity)
`else
    .out_drop   (out_drop)
`endif
  );

`ifndef MUX21_PARITY_EN
  assign out_parity = ^out;
`endif

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] o;
    logic       v;
    logic       s;
    logic       d;
    logic       p;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   vidx  = 0;
  bit   done  = 1'b0;

  function automatic exp_t got_now();
    exp_t g;
    g.o = out;
    g.v = out_valid;
    g.s = out_src;
    g.d = out_drop;
    g.p = out_parity;
    return g;
  endfunction

  task automatic check(input string nm, input exp_t e);
    exp_t g;
    g = got_now();
    n_vec++;
    if (g !== e) begin
      n_bad++;
      $display("FAIL %s: got out=%h v=%b src=%b drop=%b par=%b, want out=%h v=%b src=%b drop=%b par=%b",
               nm, g.o, g.v, g.s, g.d, g.p, e.o, e.v, e.s, e.d, e.p);
    end
  endtask

  task automatic apply(
    input logic       r,
    input logic       s,
    input logic [7:0] a,
    input logic       av,
    input logic [7:0] b,
    input logic       bv,
    input logic       h,
    input logic [7:0] eo,
    input logic       ev,
    input logic       es,
    input logic       ed
  );
    exp_t e;
    logic prev_r;
    @(negedge clk);
    prev_r     = n_rst;
    n_rst      = r;
    sel        = s;
    in_a       = a;
    in_a_valid = av;
    in_b       = b;
    in_b_valid = bv;
    hold       = h;
    e.o = eo;
    e.v = ev;
    e.s = es;
    e.d = ed;
    e.p = ^eo;
    if (prev_r && !r) begin
      #1;
      check("async_rst", e);
    end
    q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check($sformatf("vec%0d", vidx), e);
        vidx++;
      end
    end
  end

  initial begin : stim
    int budget;
    //    rst sel a      av b      bv hold | out    v  src drop
    apply(0, 0, 8'hA5, 1, 8'h00, 0, 0, 8'h00, 0, 0, 0);
    apply(0, 0, 8'hA5, 1, 8'h00, 0, 0, 8'h00, 0, 0, 0);
    apply(1, 0, 8'hA5, 1, 8'h00, 0, 0, 8'hA5, 1, 0, 0);
    apply(1, 0, 8'h12, 1, 8'h34, 0, 0, 8'h12, 1, 0, 0);
    apply(1, 1, 8'h12, 0, 8'h34, 1, 0, 8'h34, 1, 1, 0);
    apply(1, 0, 8'h01, 1, 8'h02, 1, 0, 8'h01, 1, 0, 1);
    apply(1, 0, 8'h01, 1, 8'h02, 0, 0, 8'h01, 1, 0, 0);
    apply(1, 0, 8'h55, 1, 8'h00, 0, 0, 8'h55, 1, 0, 0);
    apply(1, 0, 8'hAA, 1, 8'h00, 0, 1, 8'h55, 1, 0, 0);
    apply(1, 0, 8'hAA, 1, 8'h00, 0, 1, 8'h55, 1, 0, 0);
    apply(1, 0, 8'hAA, 1, 8'h00, 0, 1, 8'h55, 1, 0, 0);
    apply(1, 0, 8'hAA, 1, 8'h00, 0, 0, 8'hAA, 1, 0, 0);
    apply(1, 0, 8'h77, 1, 8'h00, 0, 0, 8'h77, 1, 0, 0);
    apply(1, 0, 8'h77, 0, 8'h00, 0, 0, 8'h77, 0, 0, 0);
    apply(1, 1, 8'h99, 1, 8'h00, 0, 0, 8'h77, 0, 0, 1);
    apply(1, 0, 8'h00, 1, 8'h00, 1, 1, 8'h77, 0, 0, 1);
    apply(1, 0, 8'h00, 0, 8'h00, 0, 0, 8'h77, 0, 0, 0);
    apply(1, 0, 8'h07, 1, 8'h00, 0, 0, 8'h07, 1, 0, 0);
    apply(1, 0, 8'h03, 1, 8'h00, 0, 0, 8'h03, 1, 0, 0);
    apply(1, 1, 8'h11, 1, 8'hF0, 1, 0, 8'hF0, 1, 1, 1);
    apply(0, 0, 8'h3C, 1, 8'h00, 0, 0, 8'h00, 0, 0, 0);
    apply(1, 0, 8'h3C, 1, 8'h00, 0, 0, 8'h3C, 1, 0, 0);
    budget = 20;
    while (q.size() > 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (q.size() > 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mux_21.md
# mux_21

Registered 2:1 data selector used on the operand paths of the systolic array, e.g. choosing between the preload/weight stream and the activation stream feeding a PE row. It picks one of two valid-qualified inputs each cycle, registers the result with one cycle of latency, and reports which input was used. A stall input freezes the output. A pulse flags valid data on the unselected input, which is discarded.

## Interface
- WIDTH, 8, data width of each input and of the output (≥1).

- clk  input  1  rising-edge clock.
- n_rst  input  1  asynchronous active-low reset.
- sel  input  1  source select: 0 = in_a, 1 = in_b.
- in_a  input  WIDTH  data input A.
- in_a_valid  input  1  in_a carries valid data this cycle.
- in_b  input  WIDTH  data input B.
- in_b_valid  input  1  in_b carries valid data this cycle.
- hold  input  1  stall: all output registers keep their value.
- out  output  WIDTH  registered selected data.
- out_valid  output  1  out holds data captured on the previous edge.
- out_src  output  1  value of sel when out was last captured.
- out_drop  output  1  one-cycle pulse: the unselected input was valid on the previous edge and was discarded.
- out_parity  output  1  even parity of out. Present only with MUX21_PARITY_EN.

## Operation
- Reset (n_rst = 0, asynchronous): out = 0, out_valid = 0, out_src = 0, out_drop = 0, out_parity = 0. Outputs stay at these values while n_rst is low.
- Selected valid: sv = sel ? in_b_valid : in_a_valid.
- Unselected valid: uv = sel ? in_a_valid : in_b_valid.
- Behaviour at each rising edge with hold = 0:
  - out_valid ← sv.
  - out_drop ← uv.
  - If sv = 1: out ← selected data; out_src ← sel; out_parity ← ^selected data.
  - If sv = 0: out, out_src and out_parity keep their values. The last valid data stays visible, qualified low.
- Behaviour at each rising edge with hold = 1:
  - All outputs keep their values, including out_valid and out_drop.
  - Inputs presented that cycle are ignored and not counted as dropped. Upstream must hold its data.
- Both inputs valid with hold = 0: the selected input is captured and out_drop = 1 the next cycle.
- Neither input valid: out_valid = 0 and out_drop = 0 next cycle.
- sel is sampled only at the clock edge. Changing sel between edges has no effect.
- No combinational path from any input to any output.

## Timing
- Latency is 1 cycle: data presented before edge N appears on out after edge N.
- Throughput is one item per cycle when hold = 0.
- out_drop is high for exactly one cycle per discarding edge. A sustained drop condition keeps it high on consecutive cycles.
- Reset asserted mid-stream clears outputs immediately, without waiting for a clock edge.
- The first edge after n_rst rises behaves as a normal capture edge.

## Configuration
- MUX21_PARITY_EN defined:
  - The out_parity port exists.
  - out_parity is registered alongside out and always equals ^out.
- MUX21_PARITY_EN undefined:
  - The port and its register are absent.
  - All other behaviour is identical.

## Test plan
- Reset: drive n_rst low for 2 cycles with in_a = 8'hA5 and in_a_valid = 1. Response: out = 0, out_valid = 0, out_src = 0 and out_drop = 0 throughout. Release on a negedge; the next posedge captures 8'hA5.
- Select A/B: sel = 0, in_a = 8'h12 (valid), in_b = 8'h34 (invalid). Response: out = 8'h12, out_valid = 1, out_src = 0, out_drop = 0 after one edge. Then sel = 1 with in_b valid. Response: out = 8'h34, out_src = 1.
- Drop: both inputs valid, sel = 0, in_a = 8'h01, in_b = 8'h02. Response: out = 8'h01, out_drop = 1 for one cycle. Then in_b_valid = 0. Response: out_drop = 0.
- Hold: capture 8'h55, then assert hold for 3 cycles while presenting 8'hAA (valid). Response: out = 8'h55, out_valid = 1, out_drop unchanged. Deassert hold. Response: out = 8'hAA after one edge.
- Invalid selected: capture 8'h77, then present sel = 0 with in_a_valid = 0. Response: out_valid = 0, out stays 8'h77.
- Parity (MUX21_PARITY_EN): capture 8'h07. Response: out_parity = 1. Then capture 8'h03. Response: out_parity = 0.
